elink_tx_framer: RTL and testbench

- Core-clock-domain transmit framer that sits directly upstream of the eLink TX I/O serializer and drives its 72-bit per-core-cycle input bus.
- Accepts one eMesh transaction per handshake and formats it as a 16-byte eLink packet: one sync byte, one header byte, 4+4+4 address/data bytes and two pad bytes.
- Emits the packet as two core-clock words, transposed into channel-major order. Each channel's 8-bit field is sent MSB-first by the serializer.

---
 rtl/elink_tx_framer_if.sv | 20 ++
 rtl/elink_tx_framer.sv | 111 +++++++++++
 tb/tb_elink_tx_framer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elink_tx_framer_if.sv
// eMesh transmit handshake between a transaction source (master) and the eLink TX framer (slave).
interface elink_tx_framer_if;
  logic        tx_access;
  logic        tx_write;
  logic [1:0]  tx_datamode;
  logic [3:0]  tx_ctrlmode;
  logic [31:0] tx_dstaddr;
  logic [31:0] tx_data;
  logic [31:0] tx_srcaddr;
  logic        tx_wait;

  modport master (
    output tx_access, tx_write, tx_datamode, tx_ctrlmode, tx_dstaddr, tx_data, tx_srcaddr,
    input  tx_wait
  );
  modport slave (
    input  tx_access, tx_write, tx_datamode, tx_ctrlmode, tx_dstaddr, tx_data, tx_srcaddr,
    output tx_wait
  );
endinterface

// File: rtl/elink_tx_framer.sv
// eLink TX framer: one eMesh transaction -> 16-byte packet, emitted as two channel-major
// 72-bit words for the I/O serializer (word0 = B0..B7, word1 = B8..B15).

// One channel of the transpose: slot k's bit LANE lands on field bit 7-k (sent first = slot 0).
module elink_tx_lane #(
  parameter int LANE = 0
) (
  input  logic [7:0][7:0] slots,
  output logic [7:0]      field
);
  always_comb begin
    field = '0;
    for (int k = 0; k < 8; k++) field[7-k] = slots[k][LANE];
  end
endmodule

module elink_tx_framer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK_DIV_IN,
  input  logic             IO_RESET_N,
  input  logic             elink_disable,
  elink_tx_framer_if.slave tx,
  output logic [71:0]      DATA_OUT_FROM_DEVICE,
  output logic             tx_busy,
  output logic [CNT_W-1:0] tx_pkt_cnt
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, W0, W1} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] data;
    logic [31:0] srcaddr;
  } txn_t;

  state_t                          state, state_nxt;
  txn_t                            in_txn, cap, src;
  logic                            accept, pkt_done, send_word;
  logic [15:0][7:0]                pkt;
  logic [7:0][7:0]                 slots;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_field;
  logic [7:0]                      frame_field;

  assign in_txn = {tx.tx_write, tx.tx_datamode, tx.tx_ctrlmode,
                   tx.tx_dstaddr, tx.tx_data, tx.tx_srcaddr};

  // Only W0 blocks: accepting in W1 lets packets stream with no idle slot.
  assign tx.tx_wait = (state == W0) | elink_disable | ~IO_RESET_N;
  assign accept     = tx.tx_access & ~tx.tx_wait;
  assign send_word  = accept | (state == W0);

  always_ff @(posedge CLK_DIV_IN or negedge IO_RESET_N) begin
    if (!IO_RESET_N) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pkt_done  = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = W0;
      W0:   state_nxt = W1;
      W1: begin
        pkt_done  = 1'b1;
        state_nxt = accept ? W0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word0 is built straight from the bus for 1-cycle latency; word1 comes from the capture.
  always_comb begin
    src    = (state == W0) ? cap : in_txn;
    pkt    = '0;
    pkt[1] = {src.ctrlmode, src.datamode, src.write, 1'b1};
    for (int i = 0; i < 4; i++) begin
      pkt[2+i]  = src.dstaddr[31-8*i -: 8];
      pkt[6+i]  = src.data[31-8*i -: 8];
      pkt[10+i] = src.srcaddr[31-8*i -: 8];
    end
    slots       = (state == W0) ? pkt[15:8] : pkt[7:0];
    frame_field = (state == W0) ? 8'hFF : 8'h7F;
  end

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    elink_tx_lane #(.LANE(c)) u_lane (
      .slots (slots),
      .field (lane_field[c])
    );
  end

  always_ff @(posedge CLK_DIV_IN or negedge IO_RESET_N) begin
    if (!IO_RESET_N) begin
      DATA_OUT_FROM_DEVICE <= '0;
      tx_busy              <= 1'b0;
      tx_pkt_cnt           <= '0;
      cap                  <= '0;
    end else begin
      DATA_OUT_FROM_DEVICE <= send_word ? {frame_field, lane_field} : 72'h0;
      tx_busy              <= send_word;
      if (accept)   cap        <= in_txn;
      if (pkt_done) tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_elink_tx_framer.sv
// Scoreboarded bench for elink_tx_framer; a second CNT_W=4 instance mirrors the bus for wrap checks.
module tb_elink_tx_framer;
  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] data;
    logic [31:0] srcaddr;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dis = 1'b0;
  logic [71:0] dout, dout2;
  logic        busy, busy2;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int failures = 0;
  logic [71:0] exp_q[$];

  elink_tx_framer_if bus();
  elink_tx_framer_if bus2();

  assign bus2.tx_access   = bus.tx_access;
  assign bus2.tx_write    = bus.tx_write;
  assign bus2.tx_datamode = bus.tx_datamode;
  assign bus2.tx_ctrlmode = bus.tx_ctrlmode;
  assign bus2.tx_dstaddr  = bus.tx_dstaddr;
  assign bus2.tx_data     = bus.tx_data;
  assign bus2.tx_srcaddr  = bus.tx_srcaddr;

  elink_tx_framer #(.CNT_W(16)) dut (
    .CLK_DIV_IN(clk), .IO_RESET_N(rst_n), .elink_disable(dis), .tx(bus),
    .DATA_OUT_FROM_DEVICE(dout), .tx_busy(busy), .tx_pkt_cnt(cnt)
  );

  elink_tx_framer #(.CNT_W(4)) dut4 (
    .CLK_DIV_IN(clk), .IO_RESET_N(rst_n), .elink_disable(dis), .tx(bus2),
    .DATA_OUT_FROM_DEVICE(dout2), .tx_busy(busy2), .tx_pkt_cnt(cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] model_word(txn_t t, int half);
    logic [7:0]  by [16];
    logic [71:0] w;
    by[0]  = 8'h00;
    by[1]  = {t.ctrlmode, t.datamode, t.write, 1'b1};
    by[2]  = t.dstaddr[31:24]; by[3]  = t.dstaddr[23:16];
    by[4]  = t.dstaddr[15:8];  by[5]  = t.dstaddr[7:0];
    by[6]  = t.data[31:24];    by[7]  = t.data[23:16];
    by[8]  = t.data[15:8];     by[9]  = t.data[7:0];
    by[10] = t.srcaddr[31:24]; by[11] = t.srcaddr[23:16];
    by[12] = t.srcaddr[15:8];  by[13] = t.srcaddr[7:0];
    by[14] = 8'h00;            by[15] = 8'h00;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      int s;
      s = 8*half + k;
      for (int c = 0; c < 8; c++) w[8*c+7-k] = by[s][c];
      w[64+7-k] = (s != 0);
    end
    return w;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.write    = 1'($urandom);
    t.datamode = 2'($urandom);
    t.ctrlmode = 4'($urandom);
    t.dstaddr  = $urandom;
    t.data     = $urandom;
    t.srcaddr  = $urandom;
    return t;
  endfunction

  task automatic put_txn(txn_t t);
    bus.tx_write    = t.write;
    bus.tx_datamode = t.datamode;
    bus.tx_ctrlmode = t.ctrlmode;
    bus.tx_dstaddr  = t.dstaddr;
    bus.tx_data     = t.data;
    bus.tx_srcaddr  = t.srcaddr;
    bus.tx_access   = 1'b1;
  endtask

  task automatic push_exp(txn_t t);
    exp_q.push_back(model_word(t, 0));
    exp_q.push_back(model_word(t, 1));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard: every driven word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && (busy || dout !== 72'h0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got word %h, expected no word", dout);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        if (dout !== e || busy !== 1'b1) begin
          failures++;
          $display("FAIL sb_word: got %h busy=%b, expected %h busy=1", dout, busy, e);
        end
      end
    end
  end

  task automatic test_reset();
    bus.tx_access = 1'b0;
    put_txn('0);
    bus.tx_access = 1'b0;
    rst_n = 1'b0;
    #23;
    checks++;
    if (dout !== 72'h0 || busy !== 1'b0 || cnt !== 16'h0 || bus.tx_wait !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got dout=%h busy=%b cnt=%0d wait=%b, expected 0/0/0/1",
               dout, busy, cnt, bus.tx_wait);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.tx_wait !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_wait: got %b, expected 0", bus.tx_wait);
    end
  endtask

  task automatic test_single();
    txn_t t;
    t = '{write: 1'b1, datamode: 2'b10, ctrlmode: 4'h0,
          dstaddr: 32'h8080_0000, data: 32'hDEAD_BEEF, srcaddr: 32'h1234_5678};
    put_txn(t); push_exp(t);
    tick();
    bus.tx_access = 1'b0;
    checks++;
    if (dout[71:64] !== 8'h7F || dout[7:0] !== 8'h41 || bus.tx_wait !== 1'b1) begin
      failures++;
      $display("FAIL single_word0: got frame=%h lane0=%h wait=%b, expected 7f/41/1",
               dout[71:64], dout[7:0], bus.tx_wait);
    end
    tick();
    checks++;
    if (dout[71:64] !== 8'hFF || dout[63:56] !== 8'hC0 || dout[7:0] !== 8'h40) begin
      failures++;
      $display("FAIL single_word1: got frame=%h lane7=%h lane0=%h, expected ff/c0/40",
               dout[71:64], dout[63:56], dout[7:0]);
    end
    tick();
    checks++;
    if (dout !== 72'h0 || busy !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_idle: got dout=%h busy=%b cnt=%0d, expected 0/0/1", dout, busy, cnt);
    end
  endtask

  task automatic test_back_to_back();
    txn_t p [3];
    logic [15:0] base;
    base = cnt;
    for (int i = 0; i < 3; i++) p[i] = rand_txn();
    put_txn(p[0]); push_exp(p[0]);
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      checks++;
      if (dout[71:64] !== ((cyc % 2) ? 8'hFF : 8'h7F) || busy !== 1'b1 ||
          bus.tx_wait !== ((cyc % 2) == 0)) begin
        failures++;
        $display("FAIL b2b_cycle%0d: got frame=%h busy=%b wait=%b, expected %h/1/%b",
                 cyc, dout[71:64], busy, bus.tx_wait, (cyc % 2) ? 8'hFF : 8'h7F, (cyc % 2) == 0);
      end
      if ((cyc % 2) == 0) begin
        if (cyc/2 + 1 < 3) put_txn(p[cyc/2 + 1]);
        else bus.tx_access = 1'b0;
      end else if ((cyc + 1)/2 < 3) begin
        push_exp(p[(cyc + 1)/2]);
      end
    end
    tick();
    checks++;
    if (dout !== 72'h0 || cnt !== base + 16'd3) begin
      failures++;
      $display("FAIL b2b_end: got dout=%h cnt=%0d, expected 0/%0d", dout, cnt, base + 16'd3);
    end
  endtask

  task automatic test_wait_compliance();
    txn_t a, b;
    a = rand_txn();
    b = rand_txn();
    b.dstaddr = ~a.dstaddr;
    b.srcaddr = ~a.srcaddr;
    put_txn(a); push_exp(a);
    tick();
    put_txn(b);
    checks++;
    if (bus.tx_wait !== 1'b1) begin
      failures++;
      $display("FAIL wait_w0: got wait=%b, expected 1", bus.tx_wait);
    end
    tick();
    checks++;
    if (dout !== model_word(a, 1) || bus.tx_wait !== 1'b0) begin
      failures++;
      $display("FAIL wait_word1: got %h wait=%b, expected %h wait=0",
               dout, bus.tx_wait, model_word(a, 1));
    end
    push_exp(b);
    tick();
    bus.tx_access = 1'b0;
    checks++;
    if (dout !== model_word(b, 0)) begin
      failures++;
      $display("FAIL wait_next_word0: got %h, expected %h", dout, model_word(b, 0));
    end
    tick();
    tick();
  endtask

  task automatic test_disable();
    txn_t a, b;
    a = rand_txn();
    b = rand_txn();
    put_txn(a); push_exp(a);
    tick();
    dis = 1'b1;
    put_txn(b);
    tick();
    checks++;
    if (dout !== model_word(a, 1) || bus.tx_wait !== 1'b1) begin
      failures++;
      $display("FAIL dis_word1: got %h wait=%b, expected %h wait=1",
               dout, bus.tx_wait, model_word(a, 1));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dout !== 72'h0 || busy !== 1'b0 || bus.tx_wait !== 1'b1) begin
        failures++;
        $display("FAIL dis_idle%0d: got dout=%h busy=%b wait=%b, expected 0/0/1",
                 i, dout, busy, bus.tx_wait);
      end
    end
    dis = 1'b0;
    #1;
    checks++;
    if (bus.tx_wait !== 1'b0) begin
      failures++;
      $display("FAIL dis_release_wait: got %b, expected 0", bus.tx_wait);
    end
    push_exp(b);
    tick();
    bus.tx_access = 1'b0;
    checks++;
    if (dout !== model_word(b, 0)) begin
      failures++;
      $display("FAIL dis_resume: got %h, expected %h", dout, model_word(b, 0));
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    txn_t a, c;
    a = rand_txn();
    c = rand_txn();
    put_txn(a); push_exp(a);
    tick();
    bus.tx_access = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 72'h0 || cnt !== 16'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: got dout=%h cnt=%0d busy=%b, expected 0/0/0", dout, cnt, busy);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    put_txn(c); push_exp(c);
    tick();
    bus.tx_access = 1'b0;
    checks++;
    if (dout !== model_word(c, 0)) begin
      failures++;
      $display("FAIL rst_fresh_word0: got %h, expected %h", dout, model_word(c, 0));
    end
    tick();
    tick();
    checks++;
    if (cnt !== 16'd1 || dout !== 72'h0) begin
      failures++;
      $display("FAIL rst_fresh_cnt: got cnt=%0d dout=%h, expected 1/0", cnt, dout);
    end
  endtask

  task automatic test_wrap();
    txn_t t;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      t = rand_txn();
      put_txn(t); push_exp(t);
      tick();
      bus.tx_access = 1'b0;
      tick();
      tick();
    end
    checks++;
    if (cnt4 !== 4'd1 || cnt !== 16'd17) begin
      failures++;
      $display("FAIL wrap: got cnt4=%0d cnt=%0d, expected 1/17", cnt4, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wait_compliance();
    test_disable();
    test_reset_mid();
    test_wrap();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d words outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
